// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, NOP encoding,
// instruction size and address alignment helper.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry {pc, instr} holding buffer used while the IF/ID register is stalled.
module if_skid_buf
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        full_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        full_q, full_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Clear/unload win over load so a flush can never leave a stale entry behind.
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i || unload_i) begin
      full_d  = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else begin
      full_d  = full_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory port,
// buffers one response under IF/ID stall and kills in-flight fetches on redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         valid_q, valid_d;

  logic         req_s;
  logic         skid_load_s, skid_unload_s, skid_clear_s, skid_full_s;
  logic [31:0]  skid_pc_s, skid_instr_s;

  // The port is busy in FETCH and DRAIN; derived from registered state only.
  assign req_s = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

  if_skid_buf #(
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (skid_load_s),
    .unload_i (skid_unload_s),
    .clear_i  (skid_clear_s),
    .pc_i     (addr_q),
    .instr_i  (imem_rdata_i),
    .full_o   (skid_full_s),
    .pc_o     (skid_pc_s),
    .instr_o  (skid_instr_s)
  );

  // Next-state, PC and output-pair computation; redirect overrides stall and ack.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    valid_d       = valid_q;
    skid_load_s   = 1'b0;
    skid_unload_s = 1'b0;
    skid_clear_s  = 1'b0;

    if (redirect_i) begin
      pc_d         = word_align(redirect_pc_i);
      valid_d      = 1'b0;
      out_instr_d  = NOP_INSTR;
      skid_clear_s = 1'b1;
      if (req_s && !imem_ack_i) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack_i) begin
            pc_d = pc_q + INSTR_BYTES;
            if (!valid_q || !stall_i) begin
              out_pc_d    = addr_q;
              out_instr_d = imem_rdata_i;
              valid_d     = 1'b1;
            end else begin
              skid_load_s = 1'b1;
              state_d     = ST_HOLD;
            end
          end else if (valid_q && !stall_i) begin
            valid_d     = 1'b0;
            out_instr_d = NOP_INSTR;
          end else begin
            valid_d = valid_q;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            out_pc_d      = skid_pc_s;
            out_instr_d   = skid_instr_s;
            valid_d       = skid_full_s;
            skid_unload_s = 1'b1;
            state_d       = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          // pc_q already holds the target; the returning data is dropped.
          if (imem_ack_i) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (state_d == ST_DRAIN) begin
      addr_d = addr_q;
    end else begin
      addr_d = pc_d;
    end
  end

  // State, PC and output-pair registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      out_pc_q    <= 32'h0000_0000;
      out_instr_q <= NOP_INSTR;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req_o  = req_s;
  assign imem_addr_o = addr_q;
  assign pc_o        = out_pc_q;
  assign instr_o     = out_instr_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: variable-latency memory responder, a
// program-order scoreboard, directed scenarios and a randomized stall/redirect run.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk, rst;
  logic        imem_req_o, imem_ack_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        stall_i, redirect_i, valid_o;
  logic [31:0] redirect_pc_i, pc_o, instr_o;

  int checks, failures;
  int mem_lat, rst_pulses, consumed;
  bit rand_lat;

  if_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Memory responder: ack after `lat` wait cycles, rdata = addr ^ KEY; checks handshake stability.
  task automatic mem_task();
    int          wcnt = 0;
    int          lat = 0;
    int          seen = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (seen != rst_pulses) begin
        seen = rst_pulses; pend = 1'b0; wcnt = 0;
      end
      if (rst || imem_req_o !== 1'b1) begin
        if (pend && !rst) begin
          checks++; failures++;
          $display("FAIL mem_req_dropped got req=%b exp=1 addr=%h", imem_req_o, pend_addr);
        end
        pend = 1'b0; wcnt = 0;
        imem_ack_i = 1'b0; imem_rdata_i = $urandom();
      end else begin
        checks++;
        if (imem_addr_o[1:0] !== 2'b00) begin
          failures++; $display("FAIL mem_addr_align got=%h", imem_addr_o);
        end
        if (pend) begin
          checks++;
          if (imem_addr_o !== pend_addr) begin
            failures++; $display("FAIL mem_addr_stable got=%h exp=%h", imem_addr_o, pend_addr);
          end
        end
        if (wcnt == 0) lat = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
        if (wcnt >= lat) begin
          imem_ack_i = 1'b1; imem_rdata_i = imem_addr_o ^ KEY;
          wcnt = 0; pend = 1'b0;
        end else begin
          imem_ack_i = 1'b0; imem_rdata_i = $urandom();
          wcnt++; pend = 1'b1; pend_addr = imem_addr_o;
        end
      end
    end
  endtask

  // Scoreboard: a live pair must be the next PC in program order with its memory word.
  task automatic mon_task();
    logic [31:0] exp_pc = RESET_PC;
    bit          bubble = 1'b0;
    int          seen = 0;
    forever begin
      @(negedge clk); #2;
      if (seen != rst_pulses) begin
        seen = rst_pulses; exp_pc = RESET_PC; bubble = 1'b0;
      end
      if (rst) begin
        exp_pc = RESET_PC; bubble = 1'b0;
      end else begin
        if (bubble) begin
          checks++;
          if (valid_o !== 1'b0 || instr_o !== NOP) begin
            failures++; $display("FAIL mon_bubble got valid=%b instr=%h exp valid=0 instr=%h", valid_o, instr_o, NOP);
          end
        end
        if (valid_o === 1'b1) begin
          checks++;
          if (pc_o !== exp_pc) begin
            failures++; $display("FAIL mon_pc_order got=%h exp=%h", pc_o, exp_pc);
          end
          checks++;
          if (instr_o !== (pc_o ^ KEY)) begin
            failures++; $display("FAIL mon_instr got=%h exp=%h", instr_o, pc_o ^ KEY);
          end
        end else begin
          checks++;
          if (valid_o !== 1'b0 || instr_o !== NOP) begin
            failures++; $display("FAIL mon_idle_nop got valid=%b instr=%h exp instr=%h", valid_o, instr_o, NOP);
          end
        end
        bubble = redirect_i;
        if (redirect_i) begin
          exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (valid_o === 1'b1 && !stall_i) begin
          exp_pc = exp_pc + 32'd4; consumed++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC) begin
      failures++; $display("FAIL reset_port got req=%b addr=%h exp req=0 addr=%h", imem_req_o, imem_addr_o, RESET_PC);
    end
    checks++;
    if (valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== NOP) begin
      failures++; $display("FAIL reset_out got valid=%b pc=%h instr=%h exp 0/0/%h", valid_o, pc_o, instr_o, NOP);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC || valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_first_req got req=%b addr=%h valid=%b exp 1/%h/0", imem_req_o, imem_addr_o, valid_o, RESET_PC);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || pc_o !== RESET_PC || instr_o !== (RESET_PC ^ KEY)) begin
      failures++; $display("FAIL reset_first_out got valid=%b pc=%h instr=%h exp 1/%h/%h", valid_o, pc_o, instr_o, RESET_PC, RESET_PC ^ KEY);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || pc_o !== 32'(4 * i) || instr_o !== (32'(4 * i) ^ KEY)) begin
        failures++; $display("FAIL stream_out got valid=%b pc=%h instr=%h exp pc=%h", valid_o, pc_o, instr_o, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    checks++;
    if (imem_addr_o !== 32'hC || imem_ack_i !== 1'b1) begin
      failures++; $display("FAIL stall_setup got addr=%h ack=%b exp addr=0000000c ack=1", imem_addr_o, imem_ack_i);
    end
    stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h8) begin
        failures++; $display("FAIL stall_hold got req=%b valid=%b pc=%h exp 0/1/00000008", imem_req_o, valid_o, pc_o);
      end
    end
    mem_lat = 3;
    stall_i = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_o !== 32'hC || valid_o !== 1'b1 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
      failures++; $display("FAIL stall_release got pc=%h valid=%b req=%b addr=%h exp 0000000c/1/1/00000010", pc_o, valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_drain();
    int n = 0;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || instr_o !== NOP) begin
      failures++; $display("FAIL drain_consumed got valid=%b instr=%h exp 0/%h", valid_o, instr_o, NOP);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || instr_o !== NOP || imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
      failures++; $display("FAIL drain_enter got valid=%b instr=%h req=%b addr=%h exp 0/%h/1/00000010", valid_o, instr_o, imem_req_o, imem_addr_o, NOP);
    end
    while (imem_addr_o === 32'h10 && n < 8) begin
      checks++;
      if (valid_o !== 1'b0) begin
        failures++; $display("FAIL drain_leak got valid=%b pc=%h exp valid=0", valid_o, pc_o);
      end
      @(negedge clk); n++;
    end
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || n != 2) begin
      failures++; $display("FAIL drain_next_addr got req=%b addr=%h wait=%0d exp 1/00000100/2", imem_req_o, imem_addr_o, n);
    end
    n = 0;
    while (valid_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== (32'h100 ^ KEY)) begin
      failures++; $display("FAIL drain_target got valid=%b pc=%h instr=%h exp 1/00000100/%h", valid_o, pc_o, instr_o, 32'h100 ^ KEY);
    end
    mem_lat = 0;
  endtask

  task automatic test_redirect_hold();
    int n = 0;
    stall_i = 1'b1;
    while (imem_req_o !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (imem_req_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h100) begin
      failures++; $display("FAIL hold_enter got req=%b valid=%b pc=%h exp 0/1/00000100", imem_req_o, valid_o, pc_o);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || instr_o !== NOP || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      failures++; $display("FAIL hold_redirect got valid=%b instr=%h req=%b addr=%h exp 0/%h/1/00000200", valid_o, instr_o, imem_req_o, imem_addr_o, NOP);
    end
    stall_i = 1'b0;
    n = 0;
    while (valid_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h200) begin
      failures++; $display("FAIL hold_skid_cleared got valid=%b pc=%h exp 1/00000200", valid_o, pc_o);
    end
  endtask

  task automatic test_align_wrap();
    int n = 0;
    while (!(imem_req_o === 1'b1 && imem_ack_i === 1'b1) && n < 10) begin @(negedge clk); n++; end
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      failures++; $display("FAIL align_addr got req=%b addr=%h exp 1/00000100", imem_req_o, imem_addr_o);
    end
    redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_target got=%h exp=fffffffc", imem_addr_o);
    end
    @(negedge clk);
    checks++;
    if (imem_addr_o !== 32'h0 || valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || instr_o !== 32'h5A5A_FFFC) begin
      failures++; $display("FAIL wrap_next got addr=%h valid=%b pc=%h instr=%h exp 0/1/fffffffc/5a5afffc", imem_addr_o, valid_o, pc_o, instr_o);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
      failures++; $display("FAIL wrap_out got valid=%b pc=%h exp 1/00000000", valid_o, pc_o);
    end
  endtask

  task automatic test_reset_drain();
    int          n = 0;
    logic [31:0] old_addr;
    mem_lat = 3;
    while (!(imem_req_o === 1'b1 && imem_ack_i === 1'b0) && n < 10) begin @(negedge clk); n++; end
    old_addr = imem_addr_o;
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== old_addr) begin
      failures++; $display("FAIL rdrain_enter got req=%b addr=%h exp 1/%h", imem_req_o, imem_addr_o, old_addr);
    end
    #3;
    rst = 1'b1; rst_pulses++;
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== NOP || imem_addr_o !== RESET_PC) begin
      failures++; $display("FAIL rdrain_async got req=%b valid=%b pc=%h instr=%h addr=%h exp 0/0/0/%h/%h", imem_req_o, valid_o, pc_o, instr_o, imem_addr_o, NOP, RESET_PC);
    end
    rst = 1'b0; mem_lat = 0;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC || valid_o !== 1'b0) begin
      failures++; $display("FAIL rdrain_restart got req=%b addr=%h valid=%b exp 1/%h/0", imem_req_o, imem_addr_o, valid_o, RESET_PC);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b1 || pc_o !== RESET_PC || instr_o !== (RESET_PC ^ KEY)) begin
      failures++; $display("FAIL rdrain_first got valid=%b pc=%h instr=%h exp 1/%h/%h", valid_o, pc_o, instr_o, RESET_PC, RESET_PC ^ KEY);
    end
  endtask

  task automatic test_random();
    int c0 = consumed;
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      stall_i    = ($urandom_range(0, 99) < 30);
      redirect_i = ($urandom_range(0, 99) < 6);
      redirect_pc_i = $urandom();
      if ($urandom_range(0, 9) == 0) redirect_pc_i = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
    end
    @(negedge clk);
    stall_i = 1'b0; redirect_i = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (consumed - c0 < 200) begin
      failures++; $display("FAIL random_progress got=%0d exp>=200", consumed - c0);
    end
    rand_lat = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; consumed = 0; rst_pulses = 0;
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_ack_i = 1'b0; imem_rdata_i = 32'h0; mem_lat = 0; rand_lat = 1'b0;
    fork
      mem_task();
      mon_task();
    join_none
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_hold();
    test_align_wrap();
    test_reset_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
